// File: rtl/pll_lock_reset_seq.sv
// PLL lock filter and reset sequencer: releases memory then core resets
// after stable lock, generates ce_core, retries the PLL on lock timeout.
//
// Ports:
//   clk           : PLL output clock (96 MHz)
//   rst_n         : synchronous active-low reset
//   locked        : PLL lock flag, asynchronous to clk
//   pll_rst       : PLL reset pulse during retry
//   rst_mem_n     : active-low memory-side reset
//   rst_core_n    : active-low core reset
//   ce_core       : one-cycle core clock-enable, period CE_DIV
//   ready         : high while in RUN
//   lock_loss_cnt : saturating lock-loss event count
//
// Optional feature macro: PLL_LOSS_COUNTER_EN builds the lock-loss
// counter; without it lock_loss_cnt is tied to 0.
module pll_lock_reset_seq #(
  parameter int LOCK_CYCLES    = 1024,
  parameter int MEM_GAP        = 64,
  parameter int TIMEOUT        = 1048576,
  parameter int PLL_RST_CYCLES = 16,
  parameter int CE_DIV         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       locked,
  output logic       pll_rst,
  output logic       rst_mem_n,
  output logic       rst_core_n,
  output logic       ce_core,
  output logic       ready,
  output logic [7:0] lock_loss_cnt
);

  localparam int PH_MAX =
    (PLL_RST_CYCLES > MEM_GAP) ? PLL_RST_CYCLES : MEM_GAP;

  localparam int LW = $clog2(LOCK_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int PW = $clog2(PH_MAX) + 1;
  localparam int CW = $clog2(CE_DIV) + 1;

  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0] PR_LAST   = PW'(PLL_RST_CYCLES - 1);
  localparam logic [PW-1:0] GAP_LAST  = PW'(MEM_GAP - 1);
  localparam logic [CW-1:0] CE_LAST   = CW'(CE_DIV - 1);

  if (LOCK_CYCLES < 2) begin : g_bad_lock
    $error("LOCK_CYCLES must be at least 2");
  end
  if (MEM_GAP < 1) begin : g_bad_gap
    $error("MEM_GAP must be at least 1");
  end
  if (CE_DIV < 2) begin : g_bad_ce
    $error("CE_DIV must be at least 2");
  end

  typedef enum logic [1:0] {
    WAIT_LOCK,
    PLL_RST,
    MEM_REL,
    RUN
  } state_t;

  state_t state;
  state_t next_state;

  logic          sync1;
  logic          lock_s;
  logic [LW-1:0] lock_cnt;
  logic [LW-1:0] lock_cnt_d;
  logic [TW-1:0] to_cnt;
  logic [TW-1:0] to_cnt_d;
  logic [PW-1:0] ph_cnt;
  logic [PW-1:0] ph_cnt_d;
  logic [CW-1:0] ce_cnt;
  logic [CW-1:0] ce_cnt_d;
  logic          enter;
  logic          run_stay;
  logic          ce_hit;

  // Two-flop synchronizer for the asynchronous lock flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= locked;
      lock_s <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= WAIT_LOCK;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      WAIT_LOCK: begin
        // Lock release wins over a coincident timeout.
        if (lock_s && (lock_cnt == LOCK_LAST)) begin
          next_state = MEM_REL;
        end else if (to_cnt == TO_LAST) begin
          next_state = PLL_RST;
        end
      end
      PLL_RST: begin
        if (ph_cnt == PR_LAST) begin
          next_state = WAIT_LOCK;
        end
      end
      MEM_REL: begin
        if (!lock_s) begin
          next_state = WAIT_LOCK;
        end else if (ph_cnt == GAP_LAST) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (!lock_s) begin
          next_state = WAIT_LOCK;
        end
      end
    endcase
  end

  // Every state entry restarts the state counters from zero.
  always_comb begin
    enter      = (next_state != state);
    lock_cnt_d = '0;
    to_cnt_d   = '0;
    ph_cnt_d   = '0;
    if (!enter) begin
      unique case (state)
        WAIT_LOCK: begin
          to_cnt_d = to_cnt + TW'(1);
          if (lock_s) begin
            lock_cnt_d = lock_cnt + LW'(1);
          end
        end
        PLL_RST: ph_cnt_d = ph_cnt + PW'(1);
        MEM_REL: ph_cnt_d = ph_cnt + PW'(1);
        RUN:     ph_cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_cnt <= '0;
      to_cnt   <= '0;
      ph_cnt   <= '0;
    end else begin
      lock_cnt <= lock_cnt_d;
      to_cnt   <= to_cnt_d;
      ph_cnt   <= ph_cnt_d;
    end
  end

  // Divider only advances while RUN persists, so it sits at 0 whenever
  // rst_core_n is low and the first pulse lands CE_DIV edges after release.
  always_comb begin
    run_stay = (state == RUN) && (next_state == RUN);
    ce_hit   = run_stay && (ce_cnt == CE_LAST);
    ce_cnt_d = '0;
    if (run_stay && !ce_hit) begin
      ce_cnt_d = ce_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ce_cnt <= '0;
    end else begin
      ce_cnt <= ce_cnt_d;
    end
  end

  // Outputs decoded from next_state so they move with the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pll_rst    <= 1'b0;
      rst_mem_n  <= 1'b0;
      rst_core_n <= 1'b0;
      ready      <= 1'b0;
      ce_core    <= 1'b0;
    end else begin
      pll_rst    <= (next_state == PLL_RST);
      rst_mem_n  <= (next_state == MEM_REL) || (next_state == RUN);
      rst_core_n <= (next_state == RUN);
      ready      <= (next_state == RUN);
      ce_core    <= ce_hit;
    end
  end

`ifdef PLL_LOSS_COUNTER_EN
  logic       loss_evt;
  logic [7:0] loss_q;

  // Only drops out of MEM_REL/RUN count; timeouts do not.
  assign loss_evt = ((state == MEM_REL) || (state == RUN)) &&
                    (next_state == WAIT_LOCK);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loss_q <= '0;
    end else if (loss_evt && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign lock_loss_cnt = loss_q;
`else
  assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Scoreboard bench for pll_lock_reset_seq with small parameters.
// Expected output vectors are queued by edge number and checked at negedge.
module tb_pll_lock_reset_seq;

  logic       clk;
  logic       rst_n;
  logic       locked;
  logic       pll_rst;
  logic       rst_mem_n;
  logic       rst_core_n;
  logic       ce_core;
  logic       ready;
  logic [7:0] lock_loss_cnt;

  pll_lock_reset_seq #(
    .LOCK_CYCLES   (16),
    .MEM_GAP       (8),
    .TIMEOUT       (64),
    .PLL_RST_CYCLES(4),
    .CE_DIV        (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .locked       (locked),
    .pll_rst      (pll_rst),
    .rst_mem_n    (rst_mem_n),
    .rst_core_n   (rst_core_n),
    .ce_core      (ce_core),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [12:0] v;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [12:0] o(input logic p, input logic m,
                                    input logic c, input logic ce,
                                    input logic r, input int n);
    logic [31:0] nn;
    nn = n;
    return {p, m, c, ce, r, nn[7:0]};
  endfunction

  function automatic int lc(input int n);
`ifdef PLL_LOSS_COUNTER_EN
    return (n > 255) ? 255 : n;
`else
    return 0;
`endif
  endfunction

  task automatic push(input int c, input logic [12:0] v, input string nm);
    exp_t e;
    e.cyc  = c;
    e.v    = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after an edge: rst_n is sampled low on the next edge,
  // then released together with the new locked value.
  task automatic pulse_reset(input logic lk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    locked = lk;
  endtask

  // Monitor: compares every queued expectation on its edge.
  always @(negedge clk) begin
    logic [12:0] act;
    exp_t e;
    act = {pll_rst, rst_mem_n, rst_core_n, ce_core, ready, lock_loss_cnt};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        failures++;
        $display("FAIL %s missed edge=%0d now=%0d", e.name, e.cyc, cyc);
      end else if (act !== e.v) begin
        failures++;
        $display("FAIL %s edge=%0d got=%b exp=%b (pll,mem,core,ce,rdy,cnt)",
                 e.name, cyc, act, e.v);
      end
    end
  end

  initial begin
    int b;
    int r;
    int e;
    int f;
    int d;
    rst_n  = 1'b0;
    locked = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Clean lock, then loss in RUN and re-lock.
    b = cyc + 1;
    push(b,      o(0,0,0,0,0,0), "reset_vals");
    push(b + 17, o(0,0,0,0,0,0), "mem_before");
    push(b + 18, o(0,1,0,0,0,0), "mem_rise");
    push(b + 25, o(0,1,0,0,0,0), "core_before");
    push(b + 26, o(0,1,1,0,1,0), "core_rise");
    push(b + 29, o(0,1,1,0,1,0), "ce_before");
    push(b + 30, o(0,1,1,1,1,0), "ce_first");
    push(b + 31, o(0,1,1,0,1,0), "ce_low");
    push(b + 34, o(0,1,1,1,1,0), "ce_second");
    push(b + 38, o(0,1,1,1,1,0), "ce_third");
    e = b + 40;
    f = e + 5;
    push(e + 2,  o(0,1,1,1,1,0),     "loss_e2");
    push(e + 3,  o(0,0,0,0,0,lc(1)), "loss_e3");
    push(f + 17, o(0,0,0,0,0,lc(1)), "relock_before");
    push(f + 18, o(0,1,0,0,0,lc(1)), "relock_mem");
    push(f + 26, o(0,1,1,0,1,lc(1)), "relock_core");
    push(f + 30, o(0,1,1,1,1,lc(1)), "relock_ce");
    pulse_reset(1'b1);
    wait_until(e);
    locked = 1'b0;
    wait_until(f);
    locked = 1'b1;
    wait_until(f + 32);

    // Unstable lock: three 10-cycle highs split by 1-cycle lows.
    b = cyc + 1;
    push(b + 18, o(0,0,0,0,0,0), "unst_18");
    push(b + 40, o(0,0,0,0,0,0), "unst_40");
    push(b + 50, o(0,0,0,0,0,0), "unst_50");
    push(b + 51, o(0,1,0,0,0,0), "unst_mem");
    push(b + 59, o(0,1,1,0,1,0), "unst_core");
    pulse_reset(1'b1);
    for (int k = 0; k < 3; k++) begin
      wait_until(b + 10 + 11 * k);
      locked = 1'b0;
      wait_until(b + 11 + 11 * k);
      locked = 1'b1;
    end
    wait_until(b + 60);

    // No lock: retry cadence, then reset in the middle of PLL_RST.
    b = cyc + 1;
    r = b + 201;
    push(b + 63,  o(0,0,0,0,0,0), "nl_63");
    push(b + 64,  o(1,0,0,0,0,0), "nl_pr_start");
    push(b + 67,  o(1,0,0,0,0,0), "nl_pr_end");
    push(b + 68,  o(0,0,0,0,0,0), "nl_pr_off");
    push(b + 131, o(0,0,0,0,0,0), "nl_131");
    push(b + 132, o(1,0,0,0,0,0), "nl_pr2_start");
    push(b + 135, o(1,0,0,0,0,0), "nl_pr2_end");
    push(b + 136, o(0,0,0,0,0,0), "nl_pr2_off");
    push(b + 200, o(1,0,0,0,0,0), "nl_pr3");
    push(r,       o(0,0,0,0,0,0), "rst_in_pllrst");
    push(r + 63,  o(0,0,0,0,0,0), "nl_restart_63");
    push(r + 64,  o(1,0,0,0,0,0), "nl_restart_pr");
    pulse_reset(1'b0);
    wait_until(b + 200);
    pulse_reset(1'b0);
    wait_until(r + 66);

    // Reset while in RUN with locked held high.
    b = cyc + 1;
    r = b + 29;
    push(b + 26, o(0,1,1,0,1,0), "rr_core");
    push(b + 28, o(0,1,1,0,1,0), "rr_run");
    push(r,      o(0,0,0,0,0,0), "rst_in_run");
    push(r + 17, o(0,0,0,0,0,0), "rr_before");
    push(r + 18, o(0,1,0,0,0,0), "rr_mem");
    push(r + 26, o(0,1,1,0,1,0), "rr_core2");
    push(r + 30, o(0,1,1,1,1,0), "rr_ce");
    pulse_reset(1'b1);
    wait_until(b + 28);
    pulse_reset(1'b1);
    wait_until(r + 32);

    // 300 loss events from MEM_REL; lock reacquired every 21 edges.
    b = cyc + 1;
    for (int k = 1; k <= 300; k++) begin
      if (k <= 2 || (k >= 254 && k <= 256) || k == 300) begin
        d = b + 18 + 21 * (k - 1);
        push(d + 2, o(0,1,0,0,0,lc(k - 1)), "sat_memrel");
        push(d + 3, o(0,0,0,0,0,lc(k)),     "sat_loss");
      end
    end
    pulse_reset(1'b1);
    for (int k = 1; k <= 300; k++) begin
      d = b + 18 + 21 * (k - 1);
      wait_until(d);
      locked = 1'b0;
      wait_until(d + 3);
      locked = 1'b1;
    end

    for (int i = 0; i < 50 && sb.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (sb.size() > 0) begin
      failures += sb.size();
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
